// File: rtl/mealy_seq_detector_param.sv
// Mealy serial pattern detector with a runtime-programmable PAT_LEN-bit pattern,
// overlapping/non-overlapping modes and a saturating hit counter.
module mealy_seq_detector_param #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cfg_load,
    input  logic [PAT_LEN-1:0]           cfg_pattern,
    input  logic                         cfg_overlap,
    input  logic                         in_valid,
    input  logic                         inbit,
    output logic                         detect,
    output logic                         detect_q,
    output logic [$clog2(PAT_LEN+1)-1:0] match_len,
    output logic [CNT_W-1:0]             det_count
);

    localparam int LW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic               ovl_q, ovl_d;
    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [LW-1:0]      k_q, k_d;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] cand;
    logic [LW-1:0]      j_full;
    logic [LW-1:0]      j_short;
    logic               ok;
    logic               hit;

    // Generic failure function: longest suffix of the candidate window (limited to
    // k+1 bits) that equals a pattern prefix. j_short excludes the full pattern and
    // is the resume state after an overlapping hit.
    always_comb begin
        cand    = {hist_q, inbit};
        j_full  = '0;
        j_short = '0;
        ok      = 1'b0;
        for (int n = 1; n <= PAT_LEN; n++) begin
            if (n <= int'(k_q) + 1) begin
                ok = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (cand[i] != pat_q[PAT_LEN-n+i]) ok = 1'b0;
                end
                if (ok) begin
                    j_full = LW'(n);
                    if (n < PAT_LEN) j_short = LW'(n);
                end
            end
        end
    end

    assign hit    = (j_full == LW'(PAT_LEN));
    assign detect = in_valid & ~cfg_load & hit & reset_n;

    always_comb begin
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        k_d    = k_q;
        cnt_d  = cnt_q;
        det_d  = detect;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            k_d    = '0;
            cnt_d  = '0;
        end else if (in_valid) begin
            hist_d = cand[PAT_LEN-2:0];
            if (hit) begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                if (ovl_q) begin
                    k_d = j_short;
                end else begin
                    k_d    = '0;
                    hist_d = '0;
                end
            end else begin
                k_d = j_full;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q  <= '0;
            ovl_q  <= 1'b1;
            hist_q <= '0;
            k_q    <= '0;
            det_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            k_q    <= k_d;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
        end
    end

    assign detect_q  = det_q;
    assign match_len = k_q;
    assign det_count = cnt_q;

endmodule
